pipe_sel_mux: RTL and testbench



---
 rtl/pipe_sel_mux.sv | 164 ++++++++++++++++
 tb/tb_pipe_sel_mux.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_sel_mux.sv
// Registered N-way selector with ready/valid handshake and a two-entry skid buffer.
// Binary (MODE 0) or lowest-bit-priority (MODE 1) select; invalid selects are flagged, not muxed.
module pipe_sel_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned MODE   = 0,
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       req,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } state_e;

  logic [WIDTH-1:0] in_arr [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
  end

  // Selection result for the current input beat.
  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] sel_src;
  logic             sel_err;

  if (MODE == 0) begin : g_bin
    logic unused_req;
    assign unused_req = ^req;

    always_comb begin
      sel_src  = sel;
      sel_err  = 1'b1;
      sel_data = '0;
      if (32'(sel) < NUM_IN) begin
        sel_err  = 1'b0;
        sel_data = in_arr[sel];
      end
    end
  end else begin : g_pri
    logic unused_sel;
    assign unused_sel = ^sel;

    always_comb begin
      sel_src  = '0;
      sel_err  = 1'b1;
      sel_data = '0;
      // Descending scan so the lowest set bit is the last write and wins.
      for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
        if (req[k]) begin
          sel_src = SEL_W'(k);
          sel_err = 1'b0;
        end
      end
      if (!sel_err) begin
        sel_data = in_arr[sel_src];
      end
    end
  end

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] or_data_q, sk_data_q;
  logic [SEL_W-1:0] or_src_q, sk_src_q;
  logic             or_err_q, sk_err_q;

  logic accept, handoff;
  logic load_or_in, load_or_sk, load_sk;

  assign accept  = in_valid & in_ready_q & ~flush;
  assign handoff = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d    = StOne;
            load_or_in = 1'b1;
          end
        end
        StOne: begin
          if (accept && handoff) begin
            load_or_in = 1'b1;
          end else if (accept) begin
            state_d = StFull;
            load_sk = 1'b1;
          end else if (handoff) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (handoff) begin
            state_d    = StOne;
            load_or_sk = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_ready and out_valid are registered copies of the next-state decode, so
  // neither has a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      or_data_q   <= '0;
      or_src_q    <= '0;
      or_err_q    <= 1'b0;
      sk_data_q   <= '0;
      sk_src_q    <= '0;
      sk_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      if (load_or_in) begin
        or_data_q <= sel_data;
        or_src_q  <= sel_src;
        or_err_q  <= sel_err;
      end else if (load_or_sk) begin
        or_data_q <= sk_data_q;
        or_src_q  <= sk_src_q;
        or_err_q  <= sk_err_q;
      end
      if (load_sk) begin
        sk_data_q <= sel_data;
        sk_src_q  <= sel_src;
        sk_err_q  <= sel_err;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;
  assign out_src   = or_src_q;
  assign out_err   = or_err_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Scoreboard bench for pipe_sel_mux: several parameter sets run side by side, each with
// a depth-2 FIFO reference model fed by the driver and drained by an output monitor.
module tb_pipe_sel_mux;

  localparam int NCFG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic chk(input int cfg, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, name, act, exp);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int N  = (c == 0) ? 8 : (c == 1) ? 6 : (c == 2) ? 8 : (c == 3) ? 3 : 32;
    localparam int M  = (c == 2 || c == 5) ? 1 : 0;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic            reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [N*32-1:0] in_data = '0;
    logic [SW-1:0]   sel = '0;
    logic [N-1:0]    req = '0;
    logic            in_ready, out_valid, out_err;
    logic [31:0]     out_data;
    logic [SW-1:0]   out_src;

    // Expected beats: {23'b0, err, src[7:0], data[31:0]}
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(N), .MODE(M)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_data  (in_data),
      .sel      (sel),
      .req      (req),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_src  (out_src),
      .out_err  (out_err),
      .out_valid(out_valid),
      .out_ready(out_ready)
    );

    function automatic logic [63:0] ref_beat(input logic [N*32-1:0] d, input logic [SW-1:0] s,
                                             input logic [N-1:0] r);
      int idx = 0;
      bit err = 1'b1;
      if (M == 0) begin
        idx = int'(s);
        err = (idx >= N);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (r[i]) begin
            idx = i;
            err = 1'b0;
            break;
          end
        end
      end
      ref_beat = {23'd0, err, 8'(idx), err ? 32'd0 : d[idx*32 +: 32]};
    endfunction

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cyc(input bit rs, input bit vld, input bit fl, input bit ordy,
                       input logic [SW-1:0] s, input logic [N-1:0] r, input logic [N*32-1:0] d);
      bit acc;
      @(negedge clk);
      #1;
      reset = rs; flush = fl; in_valid = vld; out_ready = ordy;
      sel = s; req = r; in_data = d;
      acc = rs && vld && !fl && exp_q.size() < 2;
      #2;
      if (!rs || fl) exp_q.delete();
      else if (acc) exp_q.push_back(ref_beat(d, s, r));
    endtask

    always begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk(c, "out_valid", out_valid, exp_q.size() > 0);
        chk(c, "in_ready", in_ready, exp_q.size() < 2);
        if (out_valid && out_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk(c, "out_data", out_data, mon_e[31:0]);
          chk(c, "out_src", out_src, mon_e[39:32]);
          chk(c, "out_err", out_err, mon_e[40]);
        end
      end
    end

    initial begin
      logic [N*32-1:0] pat, rnd;
      logic [N-1:0]    rr;
      for (int k = 0; k < N; k++) pat[k*32 +: 32] = 32'h1000_0000 + k;

      cyc(0, 1, 0, 1, '0, '0, pat);
      cyc(0, 1, 0, 1, '0, '0, pat);
      @(posedge clk);
      #1;
      chk(c, "rst_data", out_data, 0);
      chk(c, "rst_src", out_src, 0);
      chk(c, "rst_err", out_err, 0);
      chk(c, "rst_valid", out_valid, 0);
      chk(c, "rst_ready", in_ready, 1);

      // Basic, out-of-range / empty and priority selects
      cyc(1, 1, 0, 1, SW'(5), N'(32'hA4), pat);
      cyc(1, 1, 0, 1, SW'(7), '0, pat);
      cyc(1, 1, 0, 1, SW'(2), N'(32'h80), pat);
      cyc(1, 0, 0, 1, '0, '0, pat);

      // Backpressure: A held, B skidded, C refused until the first handoff
      cyc(1, 1, 0, 0, SW'(1), N'(32'h2), pat);
      cyc(1, 1, 0, 0, SW'(2), N'(32'h4), pat);
      cyc(1, 1, 0, 0, SW'(3), N'(32'h8), pat);
      cyc(1, 1, 0, 0, SW'(3), N'(32'h8), pat);
      cyc(1, 1, 0, 1, SW'(3), N'(32'h8), pat);
      cyc(1, 1, 0, 1, SW'(3), N'(32'h8), pat);
      repeat (3) cyc(1, 0, 0, 1, '0, '0, pat);

      // Flush from FULL with a concurrent beat
      cyc(1, 1, 0, 0, SW'(4), N'(32'h10), pat);
      cyc(1, 1, 0, 0, SW'(0), N'(32'h1), pat);
      cyc(1, 1, 1, 0, SW'(1), N'(32'h3), pat);
      repeat (2) cyc(1, 0, 0, 1, '0, '0, pat);

      repeat (1700) begin
        for (int k = 0; k < N; k++) rnd[k*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
          0:       rr = '0;
          1:       rr = N'(1) << $urandom_range(0, N - 1);
          default: rr = N'($urandom);
        endcase
        cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0, SW'($urandom), rr, rnd);
      end

      repeat (4) cyc(1, 0, 0, 1, '0, '0, pat);
      chk(c, "drained", exp_q.size(), 0);
      n_done++;
    end
  end

  initial begin
    int t = 0;
    while (n_done < NCFG && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < NCFG) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d of %0d configurations finished", n_done, NCFG);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
